// File: rtl/series_sum_unit.sv
// Iterative series accumulator: sum of 1..n (or 1^2..n^2) with one term per clock.
// Optional feature macro: SERIES_SUM_SQ_EN builds the sum-of-squares path and honours `mode`.
module series_sum_unit #(
    parameter int N_W   = 3,
    parameter int SUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             ovf
);

    // Handshake: `start` is accepted only while idle (busy=0); the block then
    // stays busy until the single-cycle `done` pulse, during which `sum`/`ovf`
    // are already valid and are held until the next accepted start.

    localparam int TERM_W = 2 * N_W;
    localparam int ADD_W  = ((SUM_W > TERM_W) ? SUM_W : TERM_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [N_W:0]       k;
    logic [N_W-1:0]     n_lat;
    logic [SUM_W-1:0]   acc;
    logic               acc_ovf;
    logic [TERM_W-1:0]  term;
    logic [ADD_W-1:0]   add_full;
    logic               add_ovf;
    logic [SUM_W-1:0]   acc_next;
    logic               last;

`ifdef SERIES_SUM_SQ_EN
    logic [TERM_W-1:0]  sq;
    logic [TERM_W-1:0]  sq_next;
    logic               mode_lat;

    // sq tracks k^2 incrementally: k^2 = (k-1)^2 + 2k - 1
    assign sq_next = sq + TERM_W'({k, 1'b0}) - TERM_W'(1);
    assign term    = mode_lat ? sq_next : TERM_W'(k);
`else
    logic mode_unused;

    assign mode_unused = mode;
    assign term        = TERM_W'(k);
`endif

    assign add_full = ADD_W'(acc) + ADD_W'(term);
    assign add_ovf  = |add_full[ADD_W-1:SUM_W];
    assign acc_next = add_ovf ? '1 : add_full[SUM_W-1:0];
    assign last     = (k == {1'b0, n_lat});

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (n == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            n_lat    <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            sum      <= '0;
            ovf      <= 1'b0;
`ifdef SERIES_SUM_SQ_EN
            sq       <= '0;
            mode_lat <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat   <= n;
                        k       <= (N_W+1)'(1);
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        sum     <= '0;
                        ovf     <= 1'b0;
`ifdef SERIES_SUM_SQ_EN
                        sq       <= '0;
                        mode_lat <= mode;
`endif
                    end
                end
                RUN: begin
`ifdef SERIES_SUM_SQ_EN
                    sq <= sq_next;
`endif
                    // once saturated, acc stays all ones and further adds are dropped
                    if (!acc_ovf) begin
                        acc     <= acc_next;
                        acc_ovf <= add_ovf;
                    end
                    if (last) begin
                        sum <= acc_ovf ? acc : acc_next;
                        ovf <= acc_ovf | add_ovf;
                    end else begin
                        k <= k + (N_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_series_sum_unit.sv
// Directed bench for series_sum_unit: two instances (SUM_W=8 and SUM_W=6) share stimulus
// and are checked every cycle against a job-timeline model plus hand-computed literals.
module tb_series_sum_unit;

  localparam int N_W   = 3;
  localparam int SUM_A = 8;
  localparam int SUM_B = 6;
`ifdef SERIES_SUM_SQ_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_W-1:0]   n = '0;
  logic             mode = 1'b0;
  logic             busy_a, done_a, ovf_a;
  logic [SUM_A-1:0] sum_a;
  logic             busy_b, done_b, ovf_b;
  logic [SUM_B-1:0] sum_b;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  series_sum_unit #(.N_W(N_W), .SUM_W(SUM_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode),
    .busy(busy_a), .done(done_a), .sum(sum_a), .ovf(ovf_a)
  );

  series_sum_unit #(.N_W(N_W), .SUM_W(SUM_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode),
    .busy(busy_b), .done(done_b), .sum(sum_b), .ovf(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Sum of the series with saturation at 2^w-1; the running sum is monotonic,
  // so saturating once at the end equals saturating on the first overflowing add.
  function automatic void series(input int nn, input bit md, input int w,
                                 output int res, output bit ov);
    int total;
    int max_v;
    total = 0;
    for (int k = 1; k <= nn; k++) total += (SQ_EN && md) ? k * k : k;
    max_v = (1 << w) - 1;
    ov    = (total > max_v);
    res   = ov ? max_v : total;
  endfunction

  int               edge_no   = 0;
  bit               job_valid = 1'b0;
  int               job_start = 0;
  int               job_end   = 0;
  int               res_a, res_b;
  bit               rov_a, rov_b;
  int               m_sum_a = 0, m_sum_b = 0;
  bit               m_ovf_a = 1'b0, m_ovf_b = 1'b0;
  bit               chk_en = 1'b0;
  logic [SUM_A-1:0] exp_q[$];

  // A job accepted at edge E is busy for the cycles after edges E..E+n and
  // shows done after edge E+n; the block is idle again one edge later.
  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      job_valid = 1'b0;
      m_sum_a   = 0;
      m_sum_b   = 0;
      m_ovf_a   = 1'b0;
      m_ovf_b   = 1'b0;
      exp_q.delete();
    end else begin
      if (start && (!job_valid || edge_no > job_end + 1)) begin
        job_valid = 1'b1;
        job_start = edge_no;
        job_end   = edge_no + int'(n);
        m_sum_a   = 0;
        m_sum_b   = 0;
        m_ovf_a   = 1'b0;
        m_ovf_b   = 1'b0;
        series(int'(n), mode, SUM_A, res_a, rov_a);
        series(int'(n), mode, SUM_B, res_b, rov_b);
        exp_q.push_back(SUM_A'(res_a));
      end
      if (job_valid && edge_no == job_end) begin
        m_sum_a = res_a;
        m_ovf_a = rov_a;
        m_sum_b = res_b;
        m_ovf_b = rov_b;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    bit e_busy;
    bit e_done;
    logic [SUM_A-1:0] e_sum;
    if (chk_en) begin
      e_busy = job_valid && edge_no >= job_start && edge_no <= job_end;
      e_done = job_valid && edge_no == job_end;
      check("busy_a", 32'(busy_a), 32'(e_busy));
      check("done_a", 32'(done_a), 32'(e_done));
      check("sum_a",  32'(sum_a),  32'(m_sum_a));
      check("ovf_a",  32'(ovf_a),  32'(m_ovf_a));
      check("busy_b", 32'(busy_b), 32'(e_busy));
      check("done_b", 32'(done_b), 32'(e_done));
      check("sum_b",  32'(sum_b),  32'(m_sum_b));
      check("ovf_b",  32'(ovf_b),  32'(m_ovf_b));
      if (done_a === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_done: got done with sum %0d, expected no done", sum_a);
        end else begin
          e_sum = exp_q.pop_front();
          check("sb_sum_a", 32'(sum_a), 32'(e_sum));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input int nn, input bit md,
                         input int ea, input bit oa, input int eb, input bit ob,
                         input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    n     = N_W'(nn);
    mode  = md;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done_a === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},  32'(lat), 32'(nn + 1));
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    check({tag, "_sum_a"}, 32'(sum_a), 32'(ea));
    check({tag, "_ovf_a"}, 32'(ovf_a), 32'(oa));
    check({tag, "_sum_b"}, 32'(sum_b), 32'(eb));
    check({tag, "_ovf_b"}, 32'(ovf_b), 32'(ob));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    int dones;
    int first_d;
    int second_d;

    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_sum",  32'(sum_a),  32'd0);
    check("rst_ovf",  32'(ovf_a),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(4, 1'b0, 10, 1'b0, 10, 1'b0, "n4_sum");
    run_job(4, 1'b1, SQ_EN ? 30 : 10, 1'b0, SQ_EN ? 30 : 10, 1'b0, "n4_sq");
    run_job(7, 1'b1, SQ_EN ? 140 : 28, 1'b0, SQ_EN ? 63 : 28, SQ_EN, "n7_sq");
    run_job(7, 1'b0, 28, 1'b0, 28, 1'b0, "n7_sum");
    run_job(5, 1'b1, SQ_EN ? 55 : 15, 1'b0, SQ_EN ? 55 : 15, 1'b0, "n5_sq");
    run_job(0, 1'b0, 0, 1'b0, 0, 1'b0, "n0");
    @(negedge clk);
    check("n0_busy_after", 32'(busy_a), 32'd0);

    // second start while running is ignored
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    n     = 3'd6;
    mode  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin
        start = 1'b1;
        n     = 3'd2;
      end
      if (i == 4) start = 1'b0;
      if (done_a === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("ign_lat", 32'(lat), 32'd7);
    check("ign_sum", 32'(sum_a), 32'd21);

    // reset in the middle of a run
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    n     = 3'd7;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done_a === 1'b1) seen++;
      if (i == 4) rst_n = 1'b0;
      if (i == 5) begin
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_sum",  32'(sum_a),  32'd0);
        rst_n = 1'b1;
      end
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_job(3, 1'b0, 6, 1'b0, 6, 1'b0, "after_abort");

    // start held high: re-accepted in the first idle cycle after done
    dones    = 0;
    first_d  = 0;
    second_d = 0;
    @(negedge clk);
    start = 1'b1;
    n     = 3'd2;
    mode  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        dones++;
        if (dones == 1) first_d = i;
        if (dones == 2) begin
          second_d = i;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_first_done",  32'(first_d),  32'd3);
    check("held_second_done", 32'(second_d), 32'd7);
    check("held_sum",         32'(sum_a),    32'd3);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
